gamma_lut_mc: RTL

Multi-channel, double-buffered gamma look-up stage for the video enhancement pipe. It replaces the single-channel 8-bit gamma LUT and maps each of `CH` colour components through its own `2^DW`-entry table. Every channel holds an active bank and a shadow bank. Software fills the shadow bank over the parameter bus, and the block swaps banks atomically at the next start-of-frame, so a frame is never processed with a half-written curve.

---
 rtl/gamma_lut_mc_pkg.sv | 16 +
 rtl/gamma_lut_bank.sv | 62 ++++++
 rtl/gamma_lut_mc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gamma_lut_mc_pkg.sv
// rtl/gamma_lut_mc_pkg.sv - shared types and sizes for the multi-channel gamma LUT
// Purpose: default component width and channel count, derived LUT sizes,
//          and the component and packed pixel types.
// Ports:   none (package).
package gamma_mc_pkg;

   parameter int GLUT_DW = 8;
   parameter int GLUT_CH = 3;

   localparam int GLUT_CH_W  = (GLUT_CH > 1) ? $clog2(GLUT_CH) : 1;
   localparam int GLUT_DEPTH = 1 << GLUT_DW;

   typedef logic [GLUT_DW-1:0]         glut_data_t;
   typedef logic [GLUT_CH*GLUT_DW-1:0] glut_pixel_t;

endpackage

// File: rtl/gamma_lut_bank.sv
// rtl/gamma_lut_bank.sv - double-banked LUT storage for one colour channel
// Purpose: two 2^DW x DW flop-array banks with one write port, a registered
//          datapath read port and a registered readback port.
// Ports:   clk, reset          - clock, async active-high reset (clears entries)
//          dp_clr, dp_adv      - datapath read register clear / advance
//          wr_en/bank/addr/data - write port into the selected bank
//          rd_bank/addr, rd_data - datapath read (advances with dp_adv)
//          rb_bank/addr, rb_data - readback read (every cycle)
module gamma_lut_bank
   import gamma_mc_pkg::*;
#(
   parameter int DW = GLUT_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dp_clr,
   input  logic          dp_adv,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [DW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_bank,
   input  logic [DW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          rb_bank,
   input  logic [DW-1:0] rb_addr,
   output logic [DW-1:0] rb_data
);

   localparam int DEPTH = 1 << DW;

   logic [DW-1:0] mem [2][DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++)
               mem[b][i] <= '0;
      end else if (wr_en) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Datapath read register is part of pipeline stage 1, so it obeys the
   // pipe clear and stall like the other stage-1 registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else if (dp_clr)
         rd_data <= '0;
      else if (dp_adv)
         rd_data <= mem[rd_bank][rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rb_data <= '0;
      else
         rb_data <= mem[rb_bank][rb_addr];
   end

endmodule

// File: rtl/gamma_lut_mc.sv
// rtl/gamma_lut_mc.sv - multi-channel double-buffered gamma LUT stage
// Purpose: maps each of CH components through its own 2^DW-entry curve; the
//          shadow bank is written over the parameter bus and swapped in
//          atomically at the next start-of-frame.
// Ports:   clk, reset, datapath_clr, datapath_ready - clock/reset/pipe control
//          in_valid/in_sof/in_data, ch_en        - input pixel, per-channel enable
//          out_valid/out_sof/out_data            - mapped pixel (2-stage latency)
//          glut_write_en_n, paddr, pdata         - shadow bank write
//          raddr, glut_rdata                     - shadow bank readback
//          swap_req, swap_pending, active_bank   - bank swap control/status
//          wr_err                                - sticky dropped-write flag
module gamma_lut_mc
   import gamma_mc_pkg::*;
#(
   parameter int DW      = GLUT_DW,
   parameter int CH      = GLUT_CH,
   parameter int PADDR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               datapath_clr,
   input  logic               datapath_ready,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic [CH*DW-1:0]   in_data,
   input  logic [CH-1:0]      ch_en,
   output logic               out_valid,
   output logic               out_sof,
   output logic [CH*DW-1:0]   out_data,
   input  logic               glut_write_en_n,
   input  logic [PADDR_W-1:0] paddr,
   input  logic [DW-1:0]      pdata,
   input  logic [PADDR_W-1:0] raddr,
   output logic [DW-1:0]      glut_rdata,
   input  logic               swap_req,
   output logic               swap_pending,
   output logic               active_bank,
   output logic               wr_err
);

   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

   logic [CH_W-1:0] wr_ch;
   logic [CH_W-1:0] rb_ch;
   logic            wr_ch_ok;
   logic            rb_ch_ok;
   logic            wr_req;
   logic            wr_fire;
   logic            wr_drop;
   logic            sof_accept;
   logic            swap_now;
   logic            dp_bank;
   logic            unused_addr_hi;

   assign wr_ch    = paddr[DW +: CH_W];
   assign rb_ch    = raddr[DW +: CH_W];
   assign wr_ch_ok = int'(wr_ch) < CH;
   assign rb_ch_ok = int'(rb_ch) < CH;
   assign unused_addr_hi = ^{paddr[PADDR_W-1:DW+CH_W], raddr[PADDR_W-1:DW+CH_W]};

   assign wr_req  = ~glut_write_en_n;
   assign wr_fire = wr_req & wr_ch_ok & ~swap_pending;
   assign wr_drop = wr_req & (~wr_ch_ok | swap_pending);

   // A request arriving on the SOF-accept cycle itself is honoured on that
   // SOF, and the SOF pixel is then already looked up in the new bank.
   assign sof_accept = in_valid & in_sof & datapath_ready;
   assign swap_now   = (swap_pending | swap_req) & sof_accept;
   assign dp_bank    = active_bank ^ swap_now;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_bank  <= 1'b0;
         swap_pending <= 1'b0;
         wr_err       <= 1'b0;
      end else begin
         if (swap_now) begin
            active_bank  <= ~active_bank;
            swap_pending <= 1'b0;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
         if (wr_drop)
            wr_err <= 1'b1;
      end
   end

   logic [DW-1:0] lut_q [CH];
   logic [DW-1:0] rb_q  [CH];

   for (genvar c = 0; c < CH; c++) begin : g_ch
      gamma_lut_bank #(.DW(DW)) u_bank (
         .clk     (clk),
         .reset   (reset),
         .dp_clr  (datapath_clr),
         .dp_adv  (datapath_ready),
         .wr_en   (wr_fire && (int'(wr_ch) == c)),
         .wr_bank (~active_bank),
         .wr_addr (paddr[DW-1:0]),
         .wr_data (pdata),
         .rd_bank (dp_bank),
         .rd_addr (ch_en[c] ? in_data[c*DW +: DW] : '0),
         .rd_data (lut_q[c]),
         .rb_bank (~active_bank),
         .rb_addr (raddr[DW-1:0]),
         .rb_data (rb_q[c])
      );
   end

   // Readback: the channel decode is registered alongside the bank reads.
   logic            rb_ok_q;
   logic [CH_W-1:0] rb_ch_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rb_ok_q <= 1'b0;
         rb_ch_q <= '0;
      end else begin
         rb_ok_q <= rb_ch_ok;
         rb_ch_q <= rb_ch;
      end
   end

   assign glut_rdata = rb_ok_q ? rb_q[rb_ch_q] : '0;

   // Stage 1: side-band registers that travel with the LUT read.
   logic             s1_valid;
   logic             s1_sof;
   logic [CH-1:0]    s1_en;
   logic [CH*DW-1:0] s1_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_en    <= '0;
         s1_raw   <= '0;
      end else if (datapath_clr) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_en    <= '0;
         s1_raw   <= '0;
      end else if (datapath_ready) begin
         s1_valid <= in_valid;
         s1_sof   <= in_sof;
         s1_en    <= ch_en;
         s1_raw   <= in_data;
      end
   end

   // Stage 2: per-channel choice between LUT output and bypassed raw data.
   logic [CH*DW-1:0] mux_data;

   always_comb begin
      mux_data = '0;
      for (int c = 0; c < CH; c++)
         mux_data[c*DW +: DW] = s1_en[c] ? lut_q[c] : s1_raw[c*DW +: DW];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_data  <= '0;
      end else if (datapath_clr) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_data  <= '0;
      end else if (datapath_ready) begin
         out_valid <= s1_valid;
         out_sof   <= s1_sof;
         out_data  <= mux_data;
      end
   end

endmodule
